// File: rtl/fifo_sync_fwft_64.sv
// rtl/fifo_sync_fwft_64.sv - single-clock first-word-fall-through FIFO, 64 RAM entries plus output register
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   flush        synchronous clear of pointers, flags and output stage
//   wr_data      write data
//   wr_en        write request, accepted when full=0
//   full         RAM occupancy == 64
//   almost_full  RAM occupancy >= AF_LEVEL
//   overflow     one-cycle pulse after a write attempted while full
//   rd_data      head-of-queue word, valid when rd_valid=1
//   rd_valid     output register holds a word
//   rd_ready     consumer accepts rd_data (pop on rd_valid & rd_ready)
//   count        RAM occupancy + rd_valid, 0..65

module fifo_sync_fwft_64 #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int AF_LEVEL = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] ram_cnt;

    logic ram_empty;
    logic stage_free;
    logic do_load;
    logic do_bypass;
    logic do_write;

    assign ram_cnt     = wr_ptr - rd_ptr;
    assign ram_empty   = (ram_cnt == '0);
    assign full        = (ram_cnt == (ADDR_W+1)'(DEPTH));
    assign almost_full = (ram_cnt >= (ADDR_W+1)'(AF_LEVEL));
    assign count       = ram_cnt + {{ADDR_W{1'b0}}, rd_valid};

    assign stage_free = !rd_valid || rd_ready;

    // Bypass only when the RAM is empty, so it can never overtake stored words.
    assign do_load   = !flush && stage_free && !ram_empty;
    assign do_bypass = !flush && stage_free && ram_empty && wr_en;
    // full is taken from registered pointers, so a same-cycle pop does not
    // rescue a write presented while full.
    assign do_write  = !flush && wr_en && !full && !do_bypass;

    // Storage is deliberately not reset. Read and write addresses never
    // collide while a load happens because ram_cnt > 0 implies rd_ptr != wr_ptr.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;

            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (do_load) begin
                rd_data  <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
                rd_valid <= 1'b1;
            end else if (do_bypass) begin
                rd_data  <= wr_data;
                rd_valid <= 1'b1;
            end else if (stage_free) begin
                // rd_data keeps its last value when the stage drains empty.
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_fwft_64.sv
// tb/tb_fifo_sync_fwft_64.sv - scoreboard testbench for fifo_sync_fwft_64

module tb_fifo_sync_fwft_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [6:0]  count;

    fifo_sync_fwft_64 dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the whole FIFO is one ordered queue of words.
    logic [31:0] exp_q[$];
    int          mcnt = 0;
    bit          movf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic check_state();
        int ram;
        ram = mcnt - ((mcnt > 0) ? 1 : 0);
        chk("count",       32'(count),       32'(mcnt));
        chk("rd_valid",    32'(rd_valid),    32'(mcnt > 0));
        chk("full",        32'(full),        32'(ram == 64));
        chk("almost_full", 32'(almost_full), 32'(ram >= 56));
        chk("overflow",    32'(overflow),    32'(movf));
    endtask

    // One clock of stimulus; checks the state left by the previous edge first.
    task automatic step(input bit we, input logic [31:0] wd, input bit rdy, input bit fl);
        int pre;
        @(negedge clk);
        check_state();
        wr_en    = we;
        wr_data  = wd;
        rd_ready = rdy;
        flush    = fl;
        pre = mcnt;
        if (fl) begin
            exp_q.delete();
            mcnt = 0;
            movf = 1'b0;
        end else begin
            movf = we && (pre == 65);
            if (we && pre < 65) begin
                exp_q.push_back(wd);
                mcnt++;
            end
            if (rdy && pre > 0) mcnt--;
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_valid"}, 32'(rd_valid),    32'h0);
        chk({tag, "_rd_data"},  rd_data,          32'h0);
        chk({tag, "_count"},    32'(count),       32'h0);
        chk({tag, "_full"},     32'(full),        32'h0);
        chk({tag, "_af"},       32'(almost_full), 32'h0);
        chk({tag, "_overflow"}, 32'(overflow),    32'h0);
    endtask

    // Monitor: a pop happens on the coming edge when valid & ready, unless
    // flush or reset overrides it; compare against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && !flush && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_underflow actual=0x%08h required=<no word>", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int wp;
        int rp;
        rst      = 1'b0;
        flush    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Bypass into empty FIFO with consumer stalled.
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        idle();
        chk("bypass_data", rd_data, 32'hA5A5_0001);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Fill past full, one dropped word, then write+pop while full, then drain.
        for (int i = 0; i < 66; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_sb", 32'(exp_q.size()), 32'h0);

        // Streaming across pointer wraps.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush at count 20 with a same-cycle write, then bypass of 0x1234.
        for (int i = 0; i < 20; i++) step(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_0000, 1'b1, 1'b1);
        step(1'b1, 32'h0000_1234, 1'b0, 1'b0);
        idle();
        chk("flush_bypass", rd_data, 32'h0000_1234);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges at count 10.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        check_state();
        wr_en = 1'b1;
        wr_data = 32'h4444_4444;
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        exp_q.delete();
        mcnt  = 0;
        movf  = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h5555_0001, 1'b0, 1'b0);
        idle();
        chk("post_rst_bypass", rd_data, 32'h5555_0001);

        // Randomized traffic with phases biased toward filling and draining.
        for (int blk = 0; blk < 12; blk++) begin
            wp = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 50 : 20);
            rp = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 99) < wp), $urandom(),
                     ($urandom_range(0, 99) < rp), ($urandom_range(0, 199) == 0));
            end
        end
        for (int i = 0; i < 70; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("final_sb", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
